// File: rtl/conv_1st_pkg.sv
// Shared definitions for the first-layer convolution write-back path.
// Holds the default geometry of the output feature map and the
// write-back scheduler state encoding.
package conv_1st_pkg;

    // Default geometry: result width, array columns, channels, groups per channel
    localparam int DEF_DW         = 16;
    localparam int DEF_LANES      = 8;
    localparam int DEF_CH         = 32;
    localparam int DEF_GRP_PER_CH = 2;
    localparam int DEF_AW         = $clog2(DEF_CH * DEF_GRP_PER_CH * DEF_LANES);

    // Scheduler states: idle, draining a captured group, host read issue
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HRD   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/conv_1st_wb_buf.sv
// Lane capture buffer for the write-back scheduler.
// Holds one group of LANES results and presents the lane picked by sel.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture res into the buffer on this edge
//   res        : packed results, lane k at bits [k*DW +: DW]
//   sel        : lane select for the read mux
//   lane_data  : currently stored value of lane sel
module conv_1st_wb_buf #(
    parameter int DW    = 16,
    parameter int LANES = 8,
    parameter int LW    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [LANES*DW-1:0] res,
    input  logic [LW-1:0]       sel,
    output logic [DW-1:0]       lane_data
);

    logic [DW-1:0] lane_r [LANES];

    // Capture register: loads the whole group at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                lane_r[k] <= {DW{1'b0}};
            end
        end else if (load) begin
            for (int k = 0; k < LANES; k++) begin
                lane_r[k] <= res[k*DW +: DW];
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                lane_r[k] <= lane_r[k];
            end
        end
    end

    // Lane select mux
    always_comb begin
        lane_data = lane_r[sel];
    end

endmodule

// File: rtl/conv_1st_wb_sched.sv
// Write-back scheduler for the first-layer convolution output.
// Captures a group of LANES results on valid_i, then writes one lane per
// cycle into the single-port output RAM at
//   ch*GRP_PER_CH*LANES + grp*LANES + lane.
// The same RAM port serves host reads whenever no write-back is pending;
// array write-back always wins.
//   valid_i/ch_i/res_i : result group from the array
//   clr_i              : clears group counter and overrun flag
//   ram_*              : single-port RAM interface (rdata one cycle after re)
//   hrd_req/addr/ack/data : host read handshake
//   busy, frame_done, ovf : status
module conv_1st_wb_sched
    import conv_1st_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int LANES      = DEF_LANES,
    parameter int CH         = DEF_CH,
    parameter int GRP_PER_CH = DEF_GRP_PER_CH,
    parameter int AW         = DEF_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    input  logic [$clog2(CH)-1:0]  ch_i,
    input  logic [LANES*DW-1:0]    res_i,
    input  logic                   clr_i,
    output logic                   ram_we,
    output logic                   ram_re,
    output logic [AW-1:0]          ram_addr,
    output logic [DW-1:0]          ram_wdata,
    input  logic [DW-1:0]          ram_rdata,
    input  logic                   hrd_req,
    input  logic [AW-1:0]          hrd_addr,
    output logic                   hrd_ack,
    output logic [DW-1:0]          hrd_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   ovf
);

    localparam int CHW = $clog2(CH);
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int GW  = (GRP_PER_CH > 1) ? $clog2(GRP_PER_CH) : 1;

    localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);
    localparam logic [GW-1:0]  LAST_GRP  = GW'(GRP_PER_CH - 1);
    localparam logic [CHW-1:0] LAST_CH   = CHW'(CH - 1);

    wb_state_e      state_r;
    wb_state_e      state_nxt_s;
    logic [LW-1:0]  lane_r;
    logic [LW-1:0]  lane_nxt_s;
    logic [CHW-1:0] ch_q_r;
    logic [CHW-1:0] ch_nxt_s;
    logic [GW-1:0]  grp_q_r;
    logic [GW-1:0]  grp_nxt_s;
    logic [GW-1:0]  grp_cnt_r;
    logic           capture_s;
    logic           drop_s;
    logic           grant_s;
    logic           last_lane_s;
    logic [DW-1:0]  buf_lane_s;
    logic [DW-1:0]  wdata_nxt_s;
    logic [AW-1:0]  wr_addr_nxt_s;

    logic           ram_we_r;
    logic           ram_re_r;
    logic [AW-1:0]  ram_addr_r;
    logic [DW-1:0]  ram_wdata_r;
    logic           hrd_ack_r;
    logic [DW-1:0]  hrd_hold_r;
    logic           busy_r;
    logic           frame_done_r;
    logic           ovf_r;

    // Buffer read port follows the lane that will be on the bus next cycle
    conv_1st_wb_buf #(
        .DW    (DW),
        .LANES (LANES),
        .LW    (LW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture_s),
        .res       (res_i),
        .sel       (lane_nxt_s),
        .lane_data (buf_lane_s)
    );

    // Next-state logic: capture, overrun detection and host-read grant
    always_comb begin
        last_lane_s = (lane_r == LAST_LANE);
        capture_s   = 1'b0;
        drop_s      = 1'b0;
        grant_s     = 1'b0;
        state_nxt_s = state_r;
        lane_nxt_s  = lane_r;
        case (state_r)
            ST_IDLE: begin
                capture_s = valid_i;
                // During the ack cycle the host still holds hrd_req; do not re-issue
                grant_s   = hrd_req & ~valid_i & ~hrd_ack_r;
                lane_nxt_s = {LW{1'b0}};
                if (capture_s) begin
                    state_nxt_s = ST_DRAIN;
                end else if (grant_s) begin
                    state_nxt_s = ST_HRD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HRD: begin
                capture_s  = valid_i;
                lane_nxt_s = {LW{1'b0}};
                if (capture_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (last_lane_s) begin
                    // Final lane: a new group may chain straight into the next drain
                    capture_s  = valid_i;
                    lane_nxt_s = {LW{1'b0}};
                    if (capture_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    drop_s      = valid_i;
                    lane_nxt_s  = lane_r + LW'(1);
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                lane_nxt_s  = {LW{1'b0}};
            end
        endcase
    end

    // Next write address/data, computed ahead so the RAM outputs are registered
    always_comb begin
        if (capture_s) begin
            ch_nxt_s    = ch_i;
            grp_nxt_s   = grp_cnt_r;
            wdata_nxt_s = res_i[DW-1:0];
        end else begin
            ch_nxt_s    = ch_q_r;
            grp_nxt_s   = grp_q_r;
            wdata_nxt_s = buf_lane_s;
        end
        wr_addr_nxt_s = AW'(ch_nxt_s) * AW'(GRP_PER_CH * LANES)
                      + AW'(grp_nxt_s) * AW'(LANES)
                      + AW'(lane_nxt_s);
    end

    // FSM state and drain lane counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            lane_r  <= {LW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            lane_r  <= lane_nxt_s;
        end
    end

    // Captured group identity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q_r  <= {CHW{1'b0}};
            grp_q_r <= {GW{1'b0}};
        end else if (capture_s) begin
            ch_q_r  <= ch_i;
            grp_q_r <= grp_cnt_r;
        end else begin
            ch_q_r  <= ch_q_r;
            grp_q_r <= grp_q_r;
        end
    end

    // Group counter (wraps per channel) and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_cnt_r <= {GW{1'b0}};
            ovf_r     <= 1'b0;
        end else if (clr_i) begin
            grp_cnt_r <= {GW{1'b0}};
            ovf_r     <= 1'b0;
        end else begin
            if (capture_s) begin
                grp_cnt_r <= (grp_cnt_r == LAST_GRP) ? {GW{1'b0}} : grp_cnt_r + GW'(1);
            end else begin
                grp_cnt_r <= grp_cnt_r;
            end
            ovf_r <= ovf_r | drop_s;
        end
    end

    // Registered RAM port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we_r     <= 1'b0;
            ram_re_r     <= 1'b0;
            ram_addr_r   <= {AW{1'b0}};
            ram_wdata_r  <= {DW{1'b0}};
            busy_r       <= 1'b0;
            hrd_ack_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            case (state_nxt_s)
                ST_DRAIN: begin
                    ram_we_r    <= 1'b1;
                    ram_re_r    <= 1'b0;
                    ram_addr_r  <= wr_addr_nxt_s;
                    ram_wdata_r <= wdata_nxt_s;
                    busy_r      <= 1'b1;
                end
                ST_HRD: begin
                    ram_we_r    <= 1'b0;
                    ram_re_r    <= 1'b1;
                    ram_addr_r  <= hrd_addr;
                    ram_wdata_r <= {DW{1'b0}};
                    busy_r      <= 1'b0;
                end
                default: begin
                    ram_we_r    <= 1'b0;
                    ram_re_r    <= 1'b0;
                    ram_addr_r  <= {AW{1'b0}};
                    ram_wdata_r <= {DW{1'b0}};
                    busy_r      <= 1'b0;
                end
            endcase
            hrd_ack_r    <= (state_r == ST_HRD);
            frame_done_r <= (state_r == ST_DRAIN) && last_lane_s
                            && (ch_q_r == LAST_CH) && (grp_q_r == LAST_GRP);
        end
    end

    // Host data hold register: keeps the last read value between acks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hrd_hold_r <= {DW{1'b0}};
        end else if (hrd_ack_r) begin
            hrd_hold_r <= ram_rdata;
        end else begin
            hrd_hold_r <= hrd_hold_r;
        end
    end

    // RAM data is only valid during the ack cycle; it is passed through then
    // and the held copy is shown afterwards
    assign hrd_data   = hrd_ack_r ? ram_rdata : hrd_hold_r;
    assign ram_we     = ram_we_r;
    assign ram_re     = ram_re_r;
    assign ram_addr   = ram_addr_r;
    assign ram_wdata  = ram_wdata_r;
    assign hrd_ack    = hrd_ack_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_conv_1st_wb_sched.sv
// Testbench for conv_1st_wb_sched: behavioural RAM, write-queue reference
// model and randomized plus directed stimulus.
module tb_conv_1st_wb_sched;

    localparam int DW    = conv_1st_pkg::DEF_DW;
    localparam int LANES = conv_1st_pkg::DEF_LANES;
    localparam int CH    = conv_1st_pkg::DEF_CH;
    localparam int GRP   = conv_1st_pkg::DEF_GRP_PER_CH;
    localparam int AW    = conv_1st_pkg::DEF_AW;
    localparam int DEPTH = 1 << AW;

    logic                clk;
    logic                rst_n;
    logic                valid_i;
    logic [4:0]          ch_i;
    logic [LANES*DW-1:0] res_i;
    logic                clr_i;
    logic                ram_we;
    logic                ram_re;
    logic [AW-1:0]       ram_addr;
    logic [DW-1:0]       ram_wdata;
    logic [DW-1:0]       ram_rdata;
    logic                hrd_req;
    logic [AW-1:0]       hrd_addr;
    logic                hrd_ack;
    logic [DW-1:0]       hrd_data;
    logic                busy;
    logic                frame_done;
    logic                ovf;

    conv_1st_wb_sched #(
        .DW(DW), .LANES(LANES), .CH(CH), .GRP_PER_CH(GRP), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ch_i(ch_i), .res_i(res_i),
        .clr_i(clr_i), .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .hrd_req(hrd_req),
        .hrd_addr(hrd_addr), .hrd_ack(hrd_ack), .hrd_data(hrd_data),
        .busy(busy), .frame_done(frame_done), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: read data appears one cycle after ram_re
    logic [DW-1:0] ram_mem [DEPTH];
    initial ram_rdata = '0;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model state
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          eof;
    } wr_t;

    wr_t           wq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_grp;
    bit            m_ovf, m_frame_pend, m_we_prev, m_re_prev;
    logic [AW-1:0] m_raddr;
    logic [DW-1:0] m_hdata;
    int            tests, fails, frame_cnt, hwait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        m_grp        = 0;
        m_ovf        = 1'b0;
        m_frame_pend = 1'b0;
        m_we_prev    = 1'b0;
        m_re_prev    = 1'b0;
        m_hdata      = '0;
    endtask

    // One clock: advance, then predict and check everything visible this cycle
    task automatic cycle();
        bit  e_we, e_re, e_ack, e_frame;
        wr_t w;
        int  a;
        @(posedge clk);
        #1;
        e_frame      = m_frame_pend;
        m_frame_pend = 1'b0;
        e_ack        = m_re_prev;
        if (e_ack) m_hdata = ref_mem[m_raddr];
        // Host gets the port only when it sat idle last cycle and no group arrives
        e_re = hrd_req && !valid_i && !m_we_prev && !m_re_prev;
        if (e_re) m_raddr = hrd_addr;
        if (clr_i) begin
            m_grp = 0;
            m_ovf = 1'b0;
        end
        if (valid_i) begin
            if (wq.size() == 0) begin
                for (int l = 0; l < LANES; l++) begin
                    a      = int'(ch_i) * GRP * LANES + m_grp * LANES + l;
                    w.addr = AW'(a);
                    w.data = res_i[l*DW +: DW];
                    w.eof  = (int'(ch_i) == CH - 1) && (m_grp == GRP - 1) && (l == LANES - 1);
                    wq.push_back(w);
                end
                m_grp = (m_grp + 1) % GRP;
            end else begin
                m_ovf = 1'b1;
            end
        end
        e_we = 1'b0;
        if (wq.size() > 0) begin
            w    = wq.pop_front();
            e_we = 1'b1;
            ref_mem[w.addr] = w.data;
            if (w.eof) m_frame_pend = 1'b1;
            chk("wr_addr", ram_addr, w.addr);
            chk("wr_data", ram_wdata, w.data);
        end
        chk("ram_we", ram_we, e_we);
        chk("busy", busy, e_we);
        chk("ram_re", ram_re, e_re);
        if (e_re) chk("rd_addr", ram_addr, m_raddr);
        chk("hrd_ack", hrd_ack, e_ack);
        chk("hrd_data", hrd_data, m_hdata);
        chk("frame_done", frame_done, e_frame);
        chk("ovf", ovf, m_ovf);
        if (frame_done === 1'b1) frame_cnt++;
        m_we_prev = e_we;
        m_re_prev = e_re;
        // Host side: hold the request until ack, bounded wait
        if (hrd_req) begin
            if (hrd_ack) begin
                hrd_req = 1'b0;
            end else begin
                hwait++;
                if (hwait > 200) begin
                    chk("hrd_grant_timeout", hrd_ack, 1);
                    hrd_req = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic capture(input int ch, input bit rnd);
        valid_i = 1'b1;
        ch_i    = 5'(ch);
        for (int l = 0; l < LANES; l++) begin
            res_i[l*DW +: DW] = rnd ? 16'($urandom) : 16'(16'h0010 + l);
        end
        cycle();
        valid_i = 1'b0;
    endtask

    task automatic host_req(input int addr);
        hrd_addr = AW'(addr);
        hrd_req  = 1'b1;
        hwait    = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, ram_we, 0);
        chk({tag, "_re"}, ram_re, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_wdata"}, ram_wdata, 0);
        chk({tag, "_ack"}, hrd_ack, 0);
        chk({tag, "_hdata"}, hrd_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame"}, frame_done, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        tests = 0; fails = 0; frame_cnt = 0; hwait = 0;
        rst_n = 1'b0; valid_i = 1'b0; ch_i = '0; res_i = '0; clr_i = 1'b0;
        hrd_req = 1'b0; hrd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 16'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[9'h05A] = 16'hBEEF;
        ref_mem[9'h05A] = 16'hBEEF;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Single capture ch 3 grp 0, then second capture ch 3 grp 1
        capture(3, 1'b0);
        chk("cap1_addr", ram_addr, 48);
        chk("cap1_data", ram_wdata, 16'h0010);
        idle(10);
        capture(3, 1'b0);
        chk("cap2_addr", ram_addr, 56);
        idle(10);

        // Back-to-back groups every LANES cycles
        capture(10, 1'b1);
        idle(LANES - 1);
        capture(10, 1'b1);
        idle(LANES + 2);

        // Overrun: valid during lane 3 of a drain is dropped
        capture(12, 1'b1);
        idle(3);
        capture(13, 1'b1);
        chk("ovf_set", ovf, 1);
        idle(8);

        // Clear: ovf drops and grouping restarts at 0
        clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
        chk("ovf_clr", ovf, 0);
        idle(2);
        capture(7, 1'b1);
        chk("clr_grp0_addr", ram_addr, 112);
        idle(10);

        // Host read in IDLE
        host_req(9'h05A);
        cycle();
        chk("hrd_issue_re", ram_re, 1);
        cycle();
        chk("hrd_beef", hrd_data, 16'hBEEF);
        idle(3);

        // Host request raised during a drain waits for it
        capture(9, 1'b1);
        host_req($urandom_range(0, DEPTH - 1));
        idle(12);

        // Simultaneous valid and host request in IDLE: write-back wins
        host_req($urandom_range(0, DEPTH - 1));
        capture(15, 1'b1);
        chk("prio_no_re", ram_re, 0);
        idle(12);

        // Full frame: 32 channels x 2 groups back-to-back
        clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
        frame_cnt = 0;
        for (int c = 0; c < CH; c++) begin
            for (int g = 0; g < GRP; g++) begin
                capture(c, 1'b1);
                idle(LANES - 1);
            end
        end
        idle(3);
        chk("frame_done_count", frame_cnt, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                valid_i = 1'b1;
                ch_i    = 5'($urandom_range(0, CH - 1));
                for (int l = 0; l < LANES; l++) res_i[l*DW +: DW] = 16'($urandom);
            end else if ($urandom_range(0, 99) == 0) begin
                clr_i = 1'b1;
            end
            if (!hrd_req && !hrd_ack && $urandom_range(0, 15) == 0) begin
                host_req($urandom_range(0, DEPTH - 1));
            end
            cycle();
            valid_i = 1'b0;
            clr_i   = 1'b0;
        end

        // Let traffic settle before the reset test (bounded)
        for (int i = 0; i < 300 && (hrd_req || wq.size() > 0); i++) cycle();
        idle(3);

        // Reset in the middle of a drain, at lane 4
        capture(20, 1'b1);
        idle(4);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_hold_we", ram_we, 0);
        end
        rst_n = 1'b1;
        model_reset();
        idle(3);
        capture(1, 1'b1);
        chk("post_rst_addr", ram_addr, 16);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
